// File: rtl/core_input_buf_mb_if.sv
// Bus bundle for the multi-block SHA-256 input buffer.
// The master drives writes, commits, reads and releases; the slave is the buffer.
`timescale 1ns/1ps
interface core_input_buf_mb_if #(
   parameter int WIDTH   = 32,
   parameter int NBLOCKS = 2
);
   logic [WIDTH-1:0]           din;
   logic [3:0]                 wr_addr;
   logic                       wr_en;
   logic                       wr_commit;
   logic                       wr_rdy;
   logic [WIDTH-1:0]           dout;
   logic                       rd_en;
   logic [3:0]                 rd_addr;
   logic                       rd_release;
   logic                       rd_rdy;
   logic [$clog2(NBLOCKS):0]   blk_count;

   modport master (
      output din, wr_addr, wr_en, wr_commit, rd_en, rd_addr, rd_release,
      input  wr_rdy, dout, rd_rdy, blk_count
   );

   modport slave (
      input  din, wr_addr, wr_en, wr_commit, rd_en, rd_addr, rd_release,
      output wr_rdy, dout, rd_rdy, blk_count
   );
endinterface

// File: rtl/core_input_buf_mb.sv
// Circular queue of NBLOCKS 16-word blocks feeding a SHA-256 core.
// Writer fills and commits whole blocks; reader consumes the oldest block and releases it.
`timescale 1ns/1ps
module core_input_buf_mb #(
   parameter int WIDTH   = 32,
   parameter int NBLOCKS = 2,
   parameter bit SWAP_EN = 1'b1
) (
   input logic              CLK,
   input logic              RST,
   core_input_buf_mb_if.slave bus
);
   localparam int PTR_W  = $clog2(NBLOCKS);
   localparam int CNT_W  = PTR_W + 1;
   localparam int ADDR_W = PTR_W + 4;
   localparam int DEPTH  = NBLOCKS * 16;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBLOCKS);

   function automatic logic [WIDTH-1:0] byte_rev(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH/8; i++) begin
         r[8*i +: 8] = d[WIDTH-8-8*i +: 8];
      end
      return r;
   endfunction

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [WIDTH-1:0]  dout_p1;

   logic              wr_rdy_c;
   logic              rd_rdy_c;
   logic              write_ok;
   logic              commit_ok;
   logic              release_ok;
   logic [ADDR_W-1:0] wr_phys;
   logic [ADDR_W-1:0] rd_phys;
   logic [WIDTH-1:0]  wdata;

   // Flow control depends only on the block count, so a stalled writer and
   // reader can both act in the same cycle without combinational loops.
   assign wr_rdy_c   = (count != FULL_CNT);
   assign rd_rdy_c   = (count != '0);
   assign write_ok   = bus.wr_en      && wr_rdy_c;
   assign commit_ok  = bus.wr_commit  && wr_rdy_c;
   assign release_ok = bus.rd_release && rd_rdy_c;
   assign wr_phys    = {wr_ptr, bus.wr_addr};
   assign rd_phys    = {rd_ptr, bus.rd_addr};
   assign wdata      = SWAP_EN ? byte_rev(bus.din) : bus.din;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (commit_ok)  wr_ptr <= wr_ptr + PTR_W'(1);
         if (release_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({commit_ok, release_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (write_ok) mem[wr_phys] <= wdata;
   end

   // Read stage: one-cycle latency, read-first against a same-cycle write.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dout_p1 <= '0;
      end else if (bus.rd_en) begin
         dout_p1 <= mem[rd_phys];
      end
   end

   assign bus.dout      = dout_p1;
   assign bus.wr_rdy    = wr_rdy_c;
   assign bus.rd_rdy    = rd_rdy_c;
   assign bus.blk_count = count;

   a_count_bound: assert property (@(posedge CLK) disable iff (RST) count <= FULL_CNT);
endmodule

// File: tb/tb_core_input_buf_mb.sv
// Scoreboard bench for core_input_buf_mb: a 2-block byte-swapping instance and a 4-block plain instance.
`timescale 1ns/1ps
module tb_core_input_buf_mb;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   core_input_buf_mb_if #(.WIDTH(32), .NBLOCKS(2)) ifa ();
   core_input_buf_mb_if #(.WIDTH(32), .NBLOCKS(4)) ifb ();

   core_input_buf_mb #(.WIDTH(32), .NBLOCKS(2), .SWAP_EN(1'b1)) u_a (.CLK(CLK), .RST(RST), .bus(ifa));
   core_input_buf_mb #(.WIDTH(32), .NBLOCKS(4), .SWAP_EN(1'b0)) u_b (.CLK(CLK), .RST(RST), .bus(ifb));

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb[$];
   logic [31:0] got;
   logic [31:0] e;

   task automatic idle();
      ifa.din = '0; ifa.wr_addr = '0; ifa.wr_en = 0; ifa.wr_commit = 0;
      ifa.rd_en = 0; ifa.rd_addr = '0; ifa.rd_release = 0;
      ifb.din = '0; ifb.wr_addr = '0; ifb.wr_en = 0; ifb.wr_commit = 0;
      ifb.rd_en = 0; ifb.rd_addr = '0; ifb.rd_release = 0;
   endtask

   // One clock of stimulus on the selected instance; returns #1 after the edge.
   task automatic cyc(input int sel, input logic we, input logic [3:0] wa, input logic [31:0] d,
                      input logic wc, input logic re, input logic [3:0] ra, input logic rr);
      if (sel == 0) begin
         ifa.wr_en = we; ifa.wr_addr = wa; ifa.din = d; ifa.wr_commit = wc;
         ifa.rd_en = re; ifa.rd_addr = ra; ifa.rd_release = rr;
      end else begin
         ifb.wr_en = we; ifb.wr_addr = wa; ifb.din = d; ifb.wr_commit = wc;
         ifb.rd_en = re; ifb.rd_addr = ra; ifb.rd_release = rr;
      end
      @(posedge CLK);
      #1;
      idle();
   endtask

   task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d);
      cyc(sel, 1'b1, a, d, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic commit(input int sel);
      cyc(sel, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic rel_blk(input int sel);
      cyc(sel, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1);
   endtask

   task automatic rd(input int sel, input logic [3:0] a, input logic [31:0] exp_v);
      sb.push_back(exp_v);
      cyc(sel, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, a, 1'b0);
   endtask

   function automatic logic [31:0] dout_of(input int sel);
      return (sel == 0) ? ifa.dout : ifb.dout;
   endfunction

   task automatic test_reset();
      idle();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      total++; if (ifa.wr_rdy !== 1'b1) begin bad++; $display("FAIL rst_wr_rdy got=%b exp=1", ifa.wr_rdy); end
      total++; if (ifa.rd_rdy !== 1'b0) begin bad++; $display("FAIL rst_rd_rdy got=%b exp=0", ifa.rd_rdy); end
      total++; if (ifa.blk_count !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", ifa.blk_count); end
      total++; if (ifa.dout !== 32'd0) begin bad++; $display("FAIL rst_dout got=%h exp=0", ifa.dout); end
      total++; if (ifb.blk_count !== 3'd0) begin bad++; $display("FAIL rst_cnt_b got=%0d exp=0", ifb.blk_count); end
      RST = 1'b0;
   endtask

   task automatic test_fill_swap();
      for (int i = 0; i < 16; i++) wr(0, 4'(i), 32'h00010203 + 32'(i));
      total++; if (ifa.rd_rdy !== 1'b0) begin bad++; $display("FAIL fill_pre_rd_rdy got=%b exp=0", ifa.rd_rdy); end
      commit(0);
      total++; if (ifa.wr_rdy !== 1'b1) begin bad++; $display("FAIL fill_wr_rdy got=%b exp=1", ifa.wr_rdy); end
      total++; if (ifa.rd_rdy !== 1'b1) begin bad++; $display("FAIL fill_rd_rdy got=%b exp=1", ifa.rd_rdy); end
      total++; if (ifa.blk_count !== 2'd1) begin bad++; $display("FAIL fill_cnt got=%0d exp=1", ifa.blk_count); end
      rd(0, 4'd0, 32'h03020100);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL fill_rd0 got=%h exp=%h", got, e); end
      rd(0, 4'd15, 32'h12020100);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL fill_rd15 got=%h exp=%h", got, e); end
      rel_blk(0);
      total++; if (ifa.blk_count !== 2'd0) begin bad++; $display("FAIL fill_rel_cnt got=%0d exp=0", ifa.blk_count); end
   endtask

   task automatic test_full();
      wr(0, 4'd0, 32'hAAAA0001); commit(0);
      wr(0, 4'd0, 32'hBBBB0002); commit(0);
      total++; if (ifa.wr_rdy !== 1'b0) begin bad++; $display("FAIL full_wr_rdy got=%b exp=0", ifa.wr_rdy); end
      total++; if (ifa.blk_count !== 2'd2) begin bad++; $display("FAIL full_cnt got=%0d exp=2", ifa.blk_count); end
      cyc(0, 1'b1, 4'd0, 32'hCCCCCCCC, 1'b1, 1'b0, 4'd0, 1'b0);
      total++; if (ifa.blk_count !== 2'd2) begin bad++; $display("FAIL full_ign_cnt got=%0d exp=2", ifa.blk_count); end
      rd(0, 4'd0, 32'h0100AAAA);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL full_ram_kept got=%h exp=%h", got, e); end
      rel_blk(0);
      total++; if (ifa.wr_rdy !== 1'b1) begin bad++; $display("FAIL full_rel_wr_rdy got=%b exp=1", ifa.wr_rdy); end
      total++; if (ifa.blk_count !== 2'd1) begin bad++; $display("FAIL full_rel_cnt got=%0d exp=1", ifa.blk_count); end
      rd(0, 4'd0, 32'h0200BBBB);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL full_rd_next got=%h exp=%h", got, e); end
   endtask

   task automatic test_simul();
      cyc(0, 1'b1, 4'd0, 32'h11110003, 1'b1, 1'b0, 4'd0, 1'b1);
      total++; if (ifa.blk_count !== 2'd1) begin bad++; $display("FAIL sim1_cnt got=%0d exp=1", ifa.blk_count); end
      rd(0, 4'd0, 32'h03001111);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL sim1_rd got=%h exp=%h", got, e); end
      wr(0, 4'd0, 32'h22220004); commit(0);
      total++; if (ifa.blk_count !== 2'd2) begin bad++; $display("FAIL sim2_pre_cnt got=%0d exp=2", ifa.blk_count); end
      cyc(0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b1);
      total++; if (ifa.blk_count !== 2'd1) begin bad++; $display("FAIL simfull_cnt got=%0d exp=1", ifa.blk_count); end
      total++; if (ifa.wr_rdy !== 1'b1) begin bad++; $display("FAIL simfull_wr_rdy got=%b exp=1", ifa.wr_rdy); end
      rd(0, 4'd0, 32'h04002222);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL simfull_rd got=%h exp=%h", got, e); end
      rel_blk(0);
      total++; if (ifa.rd_rdy !== 1'b0) begin bad++; $display("FAIL simempty_pre_rd_rdy got=%b exp=0", ifa.rd_rdy); end
      cyc(0, 1'b1, 4'd0, 32'h33330005, 1'b1, 1'b0, 4'd0, 1'b1);
      total++; if (ifa.blk_count !== 2'd1) begin bad++; $display("FAIL simempty_cnt got=%0d exp=1", ifa.blk_count); end
      total++; if (ifa.rd_rdy !== 1'b1) begin bad++; $display("FAIL simempty_rd_rdy got=%b exp=1", ifa.rd_rdy); end
      rd(0, 4'd0, 32'h05003333);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL simempty_rd got=%h exp=%h", got, e); end
   endtask

   task automatic test_hold();
      sb.push_back(32'h05003333);
      repeat (3) cyc(0, 1'b0, 4'd3, 32'd0, 1'b0, 1'b0, 4'd3, 1'b0);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL hold_dout got=%h exp=%h", got, e); end
   endtask

   task automatic test_noswap();
      wr(1, 4'd5, 32'hDEADBEEF); commit(1);
      rd(1, 4'd5, 32'hDEADBEEF);
      got = dout_of(1); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL noswap_rd got=%h exp=%h", got, e); end
      sb.push_back(32'hDEADBEEF);
      cyc(1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      got = dout_of(1); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL noswap_hold got=%h exp=%h", got, e); end
      rel_blk(1);
   endtask

   task automatic test_read_first();
      wr(1, 4'd7, 32'h12345678);
      sb.push_back(32'h12345678);
      cyc(1, 1'b1, 4'd7, 32'h9ABCDEF0, 1'b0, 1'b1, 4'd7, 1'b0);
      got = dout_of(1); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL rdw_old got=%h exp=%h", got, e); end
      rd(1, 4'd7, 32'h9ABCDEF0);
      got = dout_of(1); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL rdw_new got=%h exp=%h", got, e); end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 9; k++) begin
         wr(1, 4'd0, 32'(k)); commit(1);
         total++; if (ifb.blk_count !== 3'd1) begin bad++; $display("FAIL wrap_cnt k=%0d got=%0d exp=1", k, ifb.blk_count); end
         rd(1, 4'd0, 32'(k));
         got = dout_of(1); e = sb.pop_front();
         total++; if (got !== e) begin bad++; $display("FAIL wrap_rd k=%0d got=%h exp=%h", k, got, e); end
         rel_blk(1);
      end
   endtask

   task automatic test_async_reset();
      wr(0, 4'd1, 32'h55550007); commit(0);
      #2;
      RST = 1'b1;
      #1;
      total++; if (ifa.blk_count !== 2'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", ifa.blk_count); end
      total++; if (ifa.rd_rdy !== 1'b0) begin bad++; $display("FAIL arst_rd_rdy got=%b exp=0", ifa.rd_rdy); end
      total++; if (ifa.wr_rdy !== 1'b1) begin bad++; $display("FAIL arst_wr_rdy got=%b exp=1", ifa.wr_rdy); end
      total++; if (ifa.dout !== 32'd0) begin bad++; $display("FAIL arst_dout got=%h exp=0", ifa.dout); end
      #1;
      RST = 1'b0;
      wr(0, 4'd0, 32'h44440006); commit(0);
      total++; if (ifa.blk_count !== 2'd1) begin bad++; $display("FAIL arst_resume_cnt got=%0d exp=1", ifa.blk_count); end
      rd(0, 4'd0, 32'h06004444);
      got = dout_of(0); e = sb.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL arst_resume_rd got=%h exp=%h", got, e); end
   endtask

   initial begin
      test_reset();
      test_fill_swap();
      test_full();
      test_simul();
      test_hold();
      test_noswap();
      test_read_first();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
